mips_multicycle_ctrl: RTL

- Multi-cycle control FSM for the MIPS core. It replaces single-cycle decode with a sequenced IF/ID/EX/MEM/WB flow over one shared ALU and one unified memory.
- Drives the PC, IR, register file, ALU-source/ALU-op and memory strobes, and waits on a memory-ready handshake with a timeout watchdog.
- Counts retired instructions and halts on an illegal opcode or a memory timeout.

---
 rtl/mips_multicycle_ctrl_if.sv | 41 ++++
 rtl/mips_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// master = sequencer side, slave = datapath side.
interface mips_multicycle_ctrl_if #(
   parameter int CNT_WIDTH = 32
);
   logic [5:0]           opcode;
   logic [5:0]           funct;
   logic                 zero;
   logic                 memReady;
   logic                 pcWrite;
   logic                 pcWriteCond;
   logic                 iorD;
   logic                 memRead;
   logic                 memWrite;
   logic                 irWrite;
   logic                 regDst;
   logic                 memToReg;
   logic                 regWrite;
   logic                 aluSrcA;
   logic [1:0]           aluSrcB;
   logic [1:0]           aluOp;
   logic [1:0]           pcSource;
   logic [3:0]           state;
   logic                 halted;
   logic                 busError;
   logic [CNT_WIDTH-1:0] retired;

   modport master (
      input  opcode, funct, zero, memReady,
      output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
             regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
             state, halted, busError, retired
   );

   modport slave (
      output opcode, funct, zero, memReady,
      input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
             regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
             state, halted, busError, retired
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing over a shared ALU and
// unified memory, with a memory-ready watchdog and a retired-instruction counter.
module mips_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   mips_multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_READ = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WRITE= 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALU_WB   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11,
      S_JR       = 4'd12,
      S_HALT     = 4'd13,
      S_BAD14    = 4'd14,
      S_BAD15    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

   state_t               state_q, state_d;
   logic [7:0]           wait_cnt_q, wait_cnt_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;
   logic                 halted_q, halted_d;
   logic                 bus_err_q, bus_err_d;

   logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       mem_wait_state;

   // The zero flag qualifies pcWriteCond inside the datapath, not here.
   logic unused_zero;
   assign unused_zero = bus.zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         retired_q  <= '0;
         halted_q   <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         retired_q  <= retired_d;
         halted_q   <= halted_d;
         bus_err_q  <= bus_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      retired_d      = retired_q;
      halted_d       = halted_q;
      bus_err_d      = bus_err_q;
      pc_write       = 1'b0;
      pc_write_cond  = 1'b0;
      ior_d          = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      ir_write       = 1'b0;
      reg_dst        = 1'b0;
      mem_to_reg     = 1'b0;
      reg_write      = 1'b0;
      alu_src_a      = 1'b0;
      alu_src_b      = 2'b00;
      alu_op         = 2'b00;
      pc_source      = 2'b00;
      mem_wait_state = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read       = 1'b1;
            alu_src_b      = 2'b01;
            ir_write       = bus.memReady;
            pc_write       = bus.memReady;
            mem_wait_state = 1'b1;
            if (bus.memReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            if (bus.opcode == OP_RTYPE && bus.funct == FN_JR) state_d = S_JR;
            else if (bus.opcode == OP_RTYPE)                  state_d = S_EXECUTE;
            else if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = S_MEM_ADDR;
            else if (bus.opcode == OP_BEQ)                    state_d = S_BRANCH;
            else if (bus.opcode == OP_J)                      state_d = S_JUMP;
            else if (bus.opcode == OP_ADDI)                   state_d = S_ADDI_EX;
            else                                              state_d = S_HALT;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            mem_read       = 1'b1;
            ior_d          = 1'b1;
            mem_wait_state = 1'b1;
            if (bus.memReady) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write      = 1'b1;
            ior_d          = 1'b1;
            mem_wait_state = 1'b1;
            if (bus.memReady) state_d = S_FETCH;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_FETCH;
         end
         S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JR: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
            state_d   = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase

      // A ready in the timeout cycle still wins over the watchdog.
      if (mem_wait_state && !bus.memReady) begin
         if (wait_cnt_q == TIMEOUT) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
      end
      if (state_d != state_q) wait_cnt_d = '0;

      if (state_d == S_FETCH && state_q inside {S_MEM_WB, S_MEM_WRITE, S_ALU_WB,
            S_BRANCH, S_JUMP, S_ADDI_WB, S_JR})
         retired_d = retired_q + 1'b1;

      if (state_d == S_HALT) halted_d = 1'b1;

      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
      end
   end

   assign bus.pcWrite     = pc_write;
   assign bus.pcWriteCond = pc_write_cond;
   assign bus.iorD        = ior_d;
   assign bus.memRead     = mem_read;
   assign bus.memWrite    = mem_write;
   assign bus.irWrite     = ir_write;
   assign bus.regDst      = reg_dst;
   assign bus.memToReg    = mem_to_reg;
   assign bus.regWrite    = reg_write;
   assign bus.aluSrcA     = alu_src_a;
   assign bus.aluSrcB     = alu_src_b;
   assign bus.aluOp       = alu_op;
   assign bus.pcSource    = pc_source;
   assign bus.state       = state_q;
   assign bus.halted      = halted_q;
   assign bus.busError    = bus_err_q;
   assign bus.retired     = retired_q;
endmodule
